// File: rtl/texture_stream_tx.sv
// rtl/texture_stream_tx.sv - serial loader driving the texture memory 3-wire write port
module texture_stream_tx #(
    parameter int BIT_CYCLES = 4,
    parameter int GAP_CYCLES = 8,
    parameter int RST_CYCLES = 4,
    parameter int ADDR_W     = 13
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              s_valid,
    input  logic [7:0]        s_data,
    output logic              s_ready,
    output logic              write_rst,
    output logic              write_clock,
    output logic              write_data,
    output logic              busy,
    output logic [ADDR_W-1:0] byte_addr,
    output logic              wrap
);
    localparam int HALF  = BIT_CYCLES / 2;
    localparam int PH_W  = $clog2(BIT_CYCLES);
    localparam int CNT_W = $clog2(GAP_CYCLES + RST_CYCLES + 2);

    typedef enum logic [2:0] {IDLE, RST, SETTLE, READY, SHIFT, GAP} state_t;

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic [PH_W-1:0]  phase;
    logic [2:0]       slot;
    logic [7:0]       shreg;
    logic             s_ready_r;

    // A start in the acceptance cycle must not complete the handshake.
    assign s_ready = s_ready_r & ~start;

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            cnt         <= '0;
            phase       <= '0;
            slot        <= '0;
            shreg       <= '0;
            s_ready_r   <= 1'b0;
            write_rst   <= 1'b0;
            write_clock <= 1'b0;
            write_data  <= 1'b0;
            busy        <= 1'b0;
            byte_addr   <= '0;
            wrap        <= 1'b0;
        end else if (start) begin
            // write_data is left alone so the forced clock edge never coincides with a data change
            state       <= RST;
            cnt         <= '0;
            s_ready_r   <= 1'b0;
            write_rst   <= 1'b1;
            write_clock <= 1'b0;
            busy        <= 1'b1;
            byte_addr   <= '0;
            wrap        <= 1'b0;
        end else begin
            wrap <= 1'b0;
            case (state)
                IDLE: begin
                end
                RST: begin
                    if (cnt == CNT_W'(RST_CYCLES - 1)) begin
                        write_rst <= 1'b0;
                        cnt       <= '0;
                        state     <= SETTLE;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                SETTLE: begin
                    if (cnt == CNT_W'(1)) begin
                        s_ready_r <= 1'b1;
                        busy      <= 1'b0;
                        state     <= READY;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                READY: begin
                    if (s_valid) begin
                        shreg     <= s_data;
                        s_ready_r <= 1'b0;
                        busy      <= 1'b1;
                        phase     <= '0;
                        slot      <= '0;
                        state     <= SHIFT;
                    end
                end
                SHIFT: begin
                    if (phase == '0)
                        write_data <= shreg[7];
                    if (phase == PH_W'(HALF))
                        write_clock <= ~write_clock;
                    if (phase == PH_W'(BIT_CYCLES - 1)) begin
                        phase <= '0;
                        shreg <= {shreg[6:0], 1'b0};
                        slot  <= slot + 3'd1;
                        if (slot == 3'd7) begin
                            cnt   <= '0;
                            state <= GAP;
                        end
                    end else begin
                        phase <= phase + 1'b1;
                    end
                end
                GAP: begin
                    // The final gap count is the address-update cycle.
                    if (cnt == CNT_W'(GAP_CYCLES)) begin
                        byte_addr <= byte_addr + 1'b1;
                        wrap      <= &byte_addr;
                        s_ready_r <= 1'b1;
                        busy      <= 1'b0;
                        state     <= READY;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_texture_stream_tx.sv
// tb/tb_texture_stream_tx.sv - bench for texture_stream_tx with a behavioural receiver model
module tb_texture_stream_tx;
    logic        clk = 1'b0;
    logic        reset;
    logic        start       [2];
    logic        s_valid     [2];
    logic [7:0]  s_data      [2];
    logic        s_ready     [2];
    logic        write_rst   [2];
    logic        write_clock [2];
    logic        write_data  [2];
    logic        busy        [2];
    logic        wrap        [2];
    logic [12:0] ba0;
    logic [5:0]  ba1;

    int vectors = 0;
    int miscompares = 0;
    int cyc = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    texture_stream_tx #(.BIT_CYCLES(4), .GAP_CYCLES(8), .RST_CYCLES(4), .ADDR_W(13)) dut0 (
        .clk(clk), .reset(reset), .start(start[0]), .s_valid(s_valid[0]), .s_data(s_data[0]),
        .s_ready(s_ready[0]), .write_rst(write_rst[0]), .write_clock(write_clock[0]),
        .write_data(write_data[0]), .busy(busy[0]), .byte_addr(ba0), .wrap(wrap[0])
    );

    texture_stream_tx #(.BIT_CYCLES(2), .GAP_CYCLES(6), .RST_CYCLES(4), .ADDR_W(6)) dut1 (
        .clk(clk), .reset(reset), .start(start[1]), .s_valid(s_valid[1]), .s_data(s_data[1]),
        .s_ready(s_ready[1]), .write_rst(write_rst[1]), .write_clock(write_clock[1]),
        .write_data(write_data[1]), .busy(busy[1]), .byte_addr(ba1), .wrap(wrap[1])
    );

    function automatic int ba(input int i);
        return (i == 0) ? int'(ba0) : int'(ba1);
    endfunction

    function automatic int amask(input int i);
        return (i == 0) ? 8191 : 63;
    endfunction

    // Receiver: 3-flop synchroniser on both wires, any clock level change shifts in a bit,
    // and every 8th bit launches a 6-cycle write of the assembled byte.
    logic [2:0] sc [2] = '{3'b0, 3'b0};
    logic [2:0] sd [2] = '{3'b0, 3'b0};
    logic       lc [2] = '{1'b0, 1'b0};
    logic [7:0] sh [2] = '{8'h0, 8'h0};
    logic [7:0] wb [2] = '{8'h0, 8'h0};
    int nb [2] = '{0, 0};
    int wc [2] = '{0, 0};
    int ra [2] = '{0, 0};
    int nwr [2] = '{0, 0};
    int ovl [2] = '{0, 0};
    logic [7:0] mem [2][8192];

    logic pc [2] = '{1'b0, 1'b0};
    logic pd [2] = '{1'b0, 1'b0};
    int tg [2] = '{0, 0};
    int dchg [2] = '{0, 0};
    int nacc [2] = '{0, 0};
    int nwrap [2] = '{0, 0};
    int wrap_prev [2] = '{-1, -1};
    int wrap_now [2] = '{-1, -1};
    int pba [2] = '{0, 0};
    int tq_cyc[$];
    logic tq_bit[$];
    int acc0[$];
    int acc1[$];

    always @(posedge clk) begin
        for (int i = 0; i < 2; i++) begin
            pc[i] <= write_clock[i];
            pd[i] <= write_data[i];
            if (!reset) begin
                sc[i] <= {sc[i][1:0], write_clock[i]};
                sd[i] <= {sd[i][1:0], write_data[i]};
                lc[i] <= sc[i][2];
                if (write_rst[i]) begin
                    nb[i] <= 0;
                    wc[i] <= 0;
                    ra[i] <= 0;
                end else begin
                    if (wc[i] != 0) begin
                        wc[i] <= wc[i] - 1;
                        if (wc[i] == 1) begin
                            mem[i][ra[i]] <= wb[i];
                            ra[i] <= (ra[i] + 1) & amask(i);
                            nwr[i] <= nwr[i] + 1;
                        end
                    end
                    if (sc[i][2] != lc[i]) begin
                        if (wc[i] != 0) ovl[i] <= ovl[i] + 1;
                        if (nb[i] == 7) begin
                            wb[i] <= {sh[i][6:0], sd[i][2]};
                            wc[i] <= 6;
                            nb[i] <= 0;
                        end else begin
                            sh[i] <= {sh[i][6:0], sd[i][2]};
                            nb[i] <= nb[i] + 1;
                        end
                    end
                end
                if (write_clock[i] !== pc[i]) begin
                    tg[i] <= tg[i] + 1;
                    if (write_data[i] !== pd[i]) dchg[i] <= dchg[i] + 1;
                    if (i == 0) begin
                        tq_cyc.push_back(cyc);
                        tq_bit.push_back(write_data[0]);
                    end
                end
                if (s_valid[i] && s_ready[i]) begin
                    nacc[i] <= nacc[i] + 1;
                    if (i == 0) acc0.push_back(cyc);
                    else acc1.push_back(cyc);
                end
                if (wrap[i]) begin
                    nwrap[i] <= nwrap[i] + 1;
                    wrap_prev[i] <= pba[i];
                    wrap_now[i] <= ba(i);
                end
                pba[i] <= ba(i);
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic wait_ready(input int i);
        int n = 0;
        while (!s_ready[i] && n < 400) begin
            n++;
            @(negedge clk);
        end
        chk("ready_timeout", 32'(n < 400), 32'd1);
    endtask

    task automatic session(input int i);
        int hi = 0;
        int clk_hi = 0;
        int lo = 0;
        start[i] = 1'b1;
        @(negedge clk);
        start[i] = 1'b0;
        while (write_rst[i] && hi < 50) begin
            hi++;
            if (write_clock[i]) clk_hi++;
            @(negedge clk);
        end
        while (!s_ready[i] && lo < 50) begin
            lo++;
            @(negedge clk);
        end
        chk("rst_len", hi, 4);
        chk("rst_clk", clk_hi, 0);
        chk("settle_len", lo, 2);
        chk("ready_busy", 32'(busy[i]), 32'd0);
        chk("ready_addr", ba(i), 0);
    endtask

    task automatic send(input int i, input logic [7:0] d);
        int n = 0;
        s_valid[i] = 1'b1;
        s_data[i] = d;
        while (!s_ready[i] && n < 400) begin
            n++;
            @(negedge clk);
        end
        chk("send_timeout", 32'(n < 400), 32'd1);
        @(negedge clk);
        s_valid[i] = 1'b0;
        s_data[i] = 8'($urandom);
    endtask

    task automatic stream64(input int i, input int period);
        int bad = 0;
        int sz;
        for (int b = 0; b < 64; b++) send(i, 8'(b));
        wait_ready(i);
        repeat (12) @(negedge clk);
        for (int a = 0; a < 64; a++) chk("stream_mem", 32'(mem[i][a]), a);
        sz = (i == 0) ? acc0.size() : acc1.size();
        chk("stream_accepts", sz, 64);
        for (int k = 1; k < sz; k++) begin
            if (i == 0 && acc0[k] - acc0[k-1] != period) bad++;
            if (i == 1 && acc1[k] - acc1[k-1] != period) bad++;
        end
        chk("stream_spacing", bad, 0);
        chk("stream_overlap", ovl[i], 0);
    endtask

    initial begin
        logic [7:0] bits;
        logic [7:0] rexp[$];
        int bad;
        int base;
        int n;
        int w0;
        int a0;

        for (int i = 0; i < 2; i++) begin
            start[i] = 1'b0;
            s_valid[i] = 1'b0;
            s_data[i] = 8'h00;
        end
        reset = 1'b1;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        chk("reset_outs", 32'({s_ready[0], write_rst[0], write_clock[0], write_data[0], busy[0], wrap[0]}), 32'd0);
        chk("reset_addr", 32'(ba0), 32'd0);
        repeat (2) @(negedge clk);
        chk("idle_not_ready", 32'(s_ready[0]), 32'd0);

        session(0);

        tq_cyc.delete();
        tq_bit.delete();
        send(0, 8'hA5);
        wait_ready(0);
        repeat (12) @(negedge clk);
        chk("a5_toggles", tq_cyc.size(), 8);
        bits = 8'h00;
        bad = 0;
        for (int k = 0; k < tq_cyc.size() && k < 8; k++) begin
            bits = {bits[6:0], tq_bit[k]};
            if (k > 0 && tq_cyc[k] - tq_cyc[k-1] != 4) bad++;
        end
        chk("a5_bits", 32'(bits), 32'hA5);
        chk("a5_spacing", bad, 0);
        chk("a5_clk_idle", 32'(write_clock[0]), 32'd0);
        chk("a5_addr", 32'(ba0), 32'd1);
        chk("a5_mem", 32'(mem[0][0]), 32'hA5);

        session(0);
        acc0.delete();
        stream64(0, 42);
        chk("addr_after_64", 32'(ba0), 32'd64);
        chk("no_wrap0", nwrap[0], 0);

        session(1);
        acc1.delete();
        stream64(1, 24);
        chk("wrap_count", nwrap[1], 1);
        chk("wrap_from", wrap_prev[1], 63);
        chk("wrap_to", wrap_now[1], 0);

        session(1);
        for (int k = 0; k < 20; k++) begin
            repeat ($urandom_range(0, 30)) @(negedge clk);
            rexp.push_back(8'($urandom));
            send(1, rexp[k]);
        end
        wait_ready(1);
        repeat (12) @(negedge clk);
        for (int k = 0; k < 20; k++) chk("rand_mem", 32'(mem[1][k]), 32'(rexp[k]));
        chk("rand_addr", 32'(ba1), 32'd20);

        session(0);
        a0 = nacc[0];
        w0 = nwr[0];
        s_valid[0] = 1'b1;
        s_data[0] = 8'h99;
        start[0] = 1'b1;
        #1;
        chk("start_beats_accept", 32'(s_ready[0]), 32'd0);
        @(negedge clk);
        start[0] = 1'b0;
        s_valid[0] = 1'b0;
        chk("start_rst_rise", 32'(write_rst[0]), 32'd1);
        wait_ready(0);
        repeat (12) @(negedge clk);
        chk("start_no_accept", nacc[0], a0);
        chk("start_no_write", nwr[0], w0);

        send(0, 8'h11);
        wait_ready(0);
        repeat (12) @(negedge clk);
        chk("pre_abort_mem", 32'(mem[0][0]), 32'h11);
        w0 = nwr[0];
        base = tg[0];
        send(0, 8'h77);
        n = 0;
        while (tg[0] < base + 3 && n < 200) begin
            n++;
            @(negedge clk);
        end
        chk("abort_wait", 32'(n < 200), 32'd1);
        start[0] = 1'b1;
        @(negedge clk);
        start[0] = 1'b0;
        chk("abort_rst", 32'(write_rst[0]), 32'd1);
        chk("abort_clk", 32'(write_clock[0]), 32'd0);
        wait_ready(0);
        repeat (12) @(negedge clk);
        chk("abort_no_write", nwr[0], w0);
        chk("abort_mem1", 32'(mem[0][1]), 32'h01);
        send(0, 8'h3C);
        wait_ready(0);
        repeat (12) @(negedge clk);
        chk("post_abort_mem", 32'(mem[0][0]), 32'h3C);
        chk("post_abort_addr", 32'(ba0), 32'd1);
        chk("data_stable0", dchg[0], 0);
        chk("data_stable1", dchg[1], 0);

        base = tg[0];
        send(0, 8'hFF);
        n = 0;
        while (tg[0] < base + 3 && n < 200) begin
            n++;
            @(negedge clk);
        end
        repeat ($urandom_range(0, 2)) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        chk("midreset_outs", 32'({s_ready[0], write_rst[0], write_clock[0], write_data[0], busy[0], wrap[0],
                                  s_ready[1], write_rst[1], write_clock[1], write_data[1], busy[1], wrap[1]}), 32'd0);
        chk("midreset_addr", 32'(ba0) + 32'(ba1), 32'd0);
        reset = 1'b0;
        repeat (2) @(negedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
